imem_loader: RTL
================

Name: imem_loader

Overview:
- Host-side load sequencer that sits directly upstream of the pipelined ARM CPU's software control interface.
- Drives the CPU's sw_reset, sw_mem_addr, sw_mem_wdata and sw_mem_cmd inputs.
- Holds the CPU in software reset, streams host (addr, data) words into instruction memory over a valid/ready handshake, then releases the CPU to run.
- Gives a single-command program-load path, replacing manual register pokes.

Parameters:
ADDR_W, 9, instruction-memory byte-address width (matches CPU PC width)
DATA_W, 32, instruction word width
HALT_CYCLES, 4, cycles sw_reset is held before the first write is accepted (pipeline drain); range 1..15
MAX_WORDS, 128, maximum words per load session

Ports:
clk  in  1  system clock
rstb  in  1  asynchronous active-low reset
load_start  in  1  single-cycle pulse; begins a load session (honoured only in IDLE)
abort  in  1  single-cycle pulse; terminates the session into ERROR
clr_err  in  1  single-cycle pulse; leaves ERROR and returns to IDLE
host_valid  in  1  host word valid
host_ready  out  1  loader can accept a word
host_addr  in  ADDR_W  byte address of the word
host_data  in  DATA_W  instruction word
host_last  in  1  marks the final word of the session
sw_reset  out  32  to CPU: 32'd1 = hold in reset, 32'd0 = run
sw_mem_addr  out  32  to CPU: zero-extended imem address
sw_mem_wdata  out  32  to CPU: imem write data
sw_mem_cmd  out  32  to CPU: 32'd1 = write, 32'd0 = idle/read
hw_mem_rdata  in  32  from CPU: imem read data (registered, 1-cycle latency)
busy  out  1  FSM not in IDLE
done  out  1  one-cycle pulse on successful release
err  out  1  sticky error, set while in ERROR
err_code  out  2  0 none, 1 misaligned addr, 2 overflow, 3 abort/verify
word_count  out  8  words written in the current/last session

Behaviour:
- Clocking and reset: one clock, clk; reset is asynchronous and active-low, rstb.
- Reset values:
  - All outputs 0; state IDLE; sw_reset = 0 (CPU runs).
  - Reset mid-session drops the session immediately; no write is issued after rstb falls.
- FSM states: IDLE, HALT, ACCEPT, WRITE, RELEASE, ERROR, plus VREAD and VCMP only with the optional feature.
- IDLE:
  - host_ready = 0, sw_reset = 0, sw_mem_cmd = 0.
  - load_start → HALT; word_count cleared to 0.
- HALT:
  - sw_reset = 1.
  - Internal counter runs HALT_CYCLES cycles, then → ACCEPT.
- ACCEPT:
  - sw_reset = 1, host_ready = 1.
  - On host_valid & host_ready, latch host_addr and host_data, then:
    - host_addr[1:0] != 0 → ERROR, err_code = 1; word dropped.
    - word_count == MAX_WORDS → ERROR, err_code = 2.
    - Otherwise → WRITE.
  - host_last is latched with the word.
- WRITE (exactly 1 cycle):
  - sw_mem_addr = {zeros, latched addr}, sw_mem_wdata = latched data, sw_mem_cmd = 32'd1, host_ready = 0.
  - word_count increments at the end of the cycle.
  - Next state: RELEASE if last, else ACCEPT.
- Throughput: 2 cycles per word without verify.
- RELEASE (1 cycle):
  - sw_reset = 1, sw_mem_cmd = 0.
  - Next cycle → IDLE with sw_reset = 0 and done = 1 for that single cycle.
- ERROR:
  - sw_reset = 1 (CPU held), host_ready = 0, err = 1.
  - clr_err → IDLE; err and err_code are cleared on that transition.
- Abort and pulse priority:
  - abort in any state except IDLE/ERROR → ERROR, err_code = 3; takes priority over a simultaneous handshake.
  - load_start outside IDLE is ignored; abort in IDLE is ignored.
- sw_mem_cmd is 0 in every state other than WRITE.
- sw_mem_addr and sw_mem_wdata hold their last values outside WRITE/VREAD.

Optional Feature:
- Macro: LOADER_VERIFY_EN.
- With the macro defined:
  - WRITE → VREAD: same sw_mem_addr, sw_mem_cmd = 0, sw_reset = 1.
  - VREAD → VCMP: compare hw_mem_rdata with the latched data.
  - On match → ACCEPT, or RELEASE if last.
  - On mismatch → ERROR, err_code = 3.
  - Throughput: 4 cycles per word.
- Without the macro: hw_mem_rdata is unused; VREAD/VCMP do not exist; err_code 3 means abort only.

Test Plan:
- Single word: load_start; word addr 0x000 data 0xE3A01005 with last → sw_reset = 1 for HALT_CYCLES+3 cycles; one cmd=1 cycle with addr 0, wdata 0xE3A01005; done pulses; word_count = 1; sw_reset returns to 0.
- Burst of 4 words at 0x00/0x04/0x08/0x0C with host_valid held high → ready toggles every 2 cycles; 4 write cycles in order; word_count = 4; done once.
- Misaligned addr 0x006 → no write cycle; err = 1, err_code = 1; sw_reset stays 1; clr_err → IDLE, sw_reset = 0.
- abort asserted during ACCEPT together with host_valid → no write; err_code = 3; CPU held in reset.
- rstb asserted low mid-burst after 2 words → all outputs 0 asynchronously; a new load_start after reset behaves normally.
- With LOADER_VERIFY_EN, bench returns a corrupted hw_mem_rdata on word 2 → ERROR, err_code = 3, word_count = 2.

Source files
------------

// File: rtl/imem_loader.sv
// imem_loader: host-side program loader for the pipelined ARM CPU.
// Holds the CPU in software reset, streams (addr, data) words from the host into
// instruction memory over a valid/ready handshake, then releases the CPU.
// Optional read-back verify of every written word: define LOADER_VERIFY_EN.
module imem_loader #(
    parameter int unsigned ADDR_W      = 9,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned HALT_CYCLES = 4,
    parameter int unsigned MAX_WORDS   = 128
) (
    input  logic              clk,
    input  logic              rstb,
    input  logic              load_start,
    input  logic              abort,
    input  logic              clr_err,
    input  logic              host_valid,
    output logic              host_ready,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_data,
    input  logic              host_last,
    output logic [31:0]       sw_reset,
    output logic [31:0]       sw_mem_addr,
    output logic [31:0]       sw_mem_wdata,
    output logic [31:0]       sw_mem_cmd,
    input  logic [31:0]       hw_mem_rdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code,
    output logic [7:0]        word_count
);

    localparam logic [3:0] HaltCntMax = 4'(HALT_CYCLES - 1);
    localparam logic [7:0] MaxWords   = 8'(MAX_WORDS);

    localparam logic [1:0] ErrNone     = 2'd0;
    localparam logic [1:0] ErrAlign    = 2'd1;
    localparam logic [1:0] ErrOverflow = 2'd2;
    localparam logic [1:0] ErrAbort    = 2'd3;

`ifdef LOADER_VERIFY_EN
    typedef enum logic [2:0] {
        StIdle, StHalt, StAccept, StWrite, StRelease, StError, StVread, StVcmp
    } state_e;
`else
    typedef enum logic [2:0] {
        StIdle, StHalt, StAccept, StWrite, StRelease, StError
    } state_e;

    // Read data only matters for verify.
    logic unused_rdata;
    assign unused_rdata = ^hw_mem_rdata;
`endif

    state_e            state_q, state_d;
    logic [3:0]        halt_cnt_q, halt_cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              last_q, last_d;
    logic [7:0]        word_count_q, word_count_d;
    logic [1:0]        err_code_q, err_code_d;
    logic              done_q, done_d;
    logic              cpu_hold;
    logic              mem_wr;
    logic              abort_hit;

    // State and datapath registers; reset drops any session in flight.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q      <= StIdle;
            halt_cnt_q   <= 4'd0;
            addr_q       <= '0;
            data_q       <= '0;
            last_q       <= 1'b0;
            word_count_q <= 8'd0;
            err_code_q   <= ErrNone;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            halt_cnt_q   <= halt_cnt_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            last_q       <= last_d;
            word_count_q <= word_count_d;
            err_code_q   <= err_code_d;
            done_q       <= done_d;
        end
    end

    // Abort is honoured only while a session is active.
    assign abort_hit = abort && (state_q != StIdle) && (state_q != StError);

    // Next-state logic and per-state control outputs.
    always_comb begin
        state_d      = state_q;
        halt_cnt_d   = halt_cnt_q;
        addr_d       = addr_q;
        data_d       = data_q;
        last_d       = last_q;
        word_count_d = word_count_q;
        err_code_d   = err_code_q;
        done_d       = 1'b0;
        host_ready   = 1'b0;
        cpu_hold     = 1'b1;
        mem_wr       = 1'b0;

        case (state_q)
            StIdle: begin
                cpu_hold = 1'b0;
                if (load_start) begin
                    state_d      = StHalt;
                    halt_cnt_d   = 4'd0;
                    word_count_d = 8'd0;
                end
            end
            StHalt: begin
                // Let the CPU pipeline drain before touching imem.
                if (halt_cnt_q == HaltCntMax) begin
                    state_d = StAccept;
                end else begin
                    halt_cnt_d = halt_cnt_q + 4'd1;
                end
            end
            StAccept: begin
                host_ready = 1'b1;
                if (host_valid) begin
                    if (host_addr[1:0] != 2'b00) begin
                        state_d    = StError;
                        err_code_d = ErrAlign;
                    end else if (word_count_q == MaxWords) begin
                        state_d    = StError;
                        err_code_d = ErrOverflow;
                    end else begin
                        state_d = StWrite;
                        addr_d  = host_addr;
                        data_d  = host_data;
                        last_d  = host_last;
                    end
                end
            end
            StWrite: begin
                mem_wr       = 1'b1;
                word_count_d = word_count_q + 8'd1;
`ifdef LOADER_VERIFY_EN
                state_d = StVread;
`else
                state_d = last_q ? StRelease : StAccept;
`endif
            end
`ifdef LOADER_VERIFY_EN
            StVread: begin
                // Address still presented; CPU returns the word next cycle.
                state_d = StVcmp;
            end
            StVcmp: begin
                if (hw_mem_rdata[DATA_W-1:0] == data_q) begin
                    state_d = last_q ? StRelease : StAccept;
                end else begin
                    state_d    = StError;
                    err_code_d = ErrAbort;
                end
            end
`endif
            StRelease: begin
                state_d = StIdle;
                done_d  = 1'b1;
            end
            StError: begin
                if (clr_err) begin
                    state_d    = StIdle;
                    err_code_d = ErrNone;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Abort beats any simultaneous handshake; the offered word is not latched.
        if (abort_hit) begin
            state_d    = StError;
            err_code_d = ErrAbort;
            addr_d     = addr_q;
            data_d     = data_q;
            last_d     = last_q;
            done_d     = 1'b0;
        end
    end

    assign sw_reset     = {31'd0, cpu_hold};
    assign sw_mem_cmd   = {31'd0, mem_wr};
    assign sw_mem_addr  = 32'(addr_q);
    assign sw_mem_wdata = 32'(data_q);
    assign busy         = (state_q != StIdle);
    assign err          = (state_q == StError);
    assign err_code     = err_code_q;
    assign done         = done_q;
    assign word_count   = word_count_q;

endmodule
